// File: rtl/vedic8mul_seq_ctrl.sv
// vedic8mul_seq_ctrl: sequential 8x8 unsigned multiplier that time-shares a single 4x4 Vedic multiplier over four partial products
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready, a, b : operand handshake, 8-bit unsigned operands
//   out_valid/out_ready, p  : result handshake, 16-bit unsigned product
//   busy                  : high whenever the controller is not idle
module vedic2mul (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] c
);
    logic t, u, v, k;
    assign t = a[1] & b[0];
    assign u = a[0] & b[1];
    assign v = a[1] & b[1];
    assign k = t & u;
    assign c = {v & k, v ^ k, t ^ u, a[0] & b[0]};
endmodule

module vedic4mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] c
);
    logic [3:0] q0, q1, q2, q3;
    vedic2mul u_ll (.a(a[1:0]), .b(b[1:0]), .c(q0));
    vedic2mul u_hl (.a(a[3:2]), .b(b[1:0]), .c(q1));
    vedic2mul u_lh (.a(a[1:0]), .b(b[3:2]), .c(q2));
    vedic2mul u_hh (.a(a[3:2]), .b(b[3:2]), .c(q3));
    assign c = {4'd0, q0} + {2'd0, q1, 2'd0} + {2'd0, q2, 2'd0} + {q3, 4'd0};
endmodule

module vedic8mul_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [3:0]  ma, mb;
    logic [7:0]  c;
    logic [15:0] pp;
    logic        mul_en;
    // Outside MUL the multiplier sees the step-0 nibbles and its result is unused
    assign mul_en = state_q == MUL;
    assign ma = (mul_en && step_q[1]) ? a_q[7:4] : a_q[3:0];
    assign mb = (mul_en && step_q[0]) ? b_q[7:4] : b_q[3:0];
    vedic4mul u_mul (.a(ma), .b(mb), .c(c));
    assign pp = step_q == 2'd3 ? {c, 8'd0} : step_q == 2'd0 ? {8'd0, c} : {4'd0, c, 4'd0};
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            acc_q   <= 16'd0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                acc_d   = 16'd0;
                step_d  = 2'd0;
                state_d = MUL;
            end
            MUL: begin
                acc_d   = acc_q + pp;
                step_d  = step_q + 2'd1;
                state_d = step_q == 2'd3 ? DONE : MUL;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign p         = acc_q;
endmodule

// File: doc/vedic8mul_seq_ctrl.md
VEDIC8MUL_SEQ_CTRL -- requirements
Module: vedic8mul_seq_ctrl

Interface
REQ-001 Parameters: none; widths SHALL be fixed at 8x8 operands with a 16-bit product.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  8  multiplicand, unsigned.
REQ-007 b  input  8  multiplier, unsigned.
REQ-008 out_valid  output  1  p holds a completed product.
REQ-009 out_ready  input  1  consumer accepts p.
REQ-010 p  output  16  product a*b, unsigned.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL instantiate exactly one vedic4mul (4-bit a, 4-bit b, 8-bit c), time-shared across four partial products; no other multiplier SHALL be inferred.
REQ-013 FSM states SHALL be IDLE, MUL, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 Accept: in_valid&&in_ready at an edge SHALL register a, b, clear the accumulator, set step=0, and move IDLE->MUL.
REQ-015 In MUL, step k SHALL drive the vedic4mul inputs as: k=0 a[3:0],b[3:0] shift 0; k=1 a[3:0],b[7:4] shift 4; k=2 a[7:4],b[3:0] shift 4; k=3 a[7:4],b[7:4] shift 8.
REQ-016 Each MUL edge SHALL add the zero-extended, shifted c to the 16-bit accumulator and increment step (2-bit counter).
REQ-017 At the step=3 edge, MUL SHALL move to DONE; out_valid SHALL rise exactly 4 edges after the accept edge.
REQ-018 Accumulator arithmetic SHALL be 16-bit unsigned; the final sum SHALL never overflow (max 0xFE01).
REQ-019 p SHALL equal the accumulator and SHALL stay stable while out_valid=1.
REQ-020 DONE SHALL hold while out_ready=0; on an out_valid&&out_ready edge the FSM SHALL move to IDLE (in_ready=1 on the next cycle).
REQ-021 in_valid asserted in MUL or DONE SHALL be ignored; the registered operands SHALL NOT change.
REQ-022 Changes on a/b after the accept edge SHALL NOT affect the in-flight product.
REQ-023 Throughput: one product per 6 cycles minimum (accept, 4 MUL, DONE with out_ready=1).
REQ-024 The step counter SHALL never wrap inside MUL; reaching step=3 SHALL always exit to DONE.
REQ-025 When unused (IDLE/DONE), the vedic4mul inputs SHALL be held at step-0 selection; their output SHALL be ignored.

Reset
REQ-026 rst=1 at an edge SHALL force: state=IDLE, step=0, accumulator=0, registered a/b=0; hence in_ready=1, out_valid=0, busy=0, p=0.
REQ-027 rst SHALL take priority over every other event, including an accept or an out handshake at the same edge.
REQ-028 rst during MUL or DONE SHALL abort the operation with no out_valid pulse; the first accept after rst deassertion SHALL be honoured.

Verification
REQ-029 a=0, b=0, out_ready=1 -> out_valid 4 edges after accept, p=0x0000, then in_ready=1.
REQ-030 a=0xFF, b=0xFF -> p=0xFE01 (65025); a=0x0F, b=0x0F -> p=0x00E1.
REQ-031 a=0x35, b=0xA9, out_ready=0 for 3 cycles after out_valid -> p=0x22FD held stable; in_valid pulses with a=0x11, b=0x11 during MUL/DONE -> ignored.
REQ-032 rst=1 asserted at the second MUL edge of a=0x80, b=0x02 -> next cycle in_ready=1, out_valid=0, p=0; a new request a=0x02, b=0x0A -> p=0x0014.
REQ-033 Back-to-back: in_valid held high with out_ready=1 over 3 operand pairs -> 3 products correct, accepts spaced exactly 6 cycles.
REQ-034 Random: 1000 random a/b pairs with random out_ready stalls -> every p == a*b, in order.
